// File: rtl/cnt_pkg.sv
// Shared helpers for the modulo-N up/down counter.
// Width function, direction constants and Gray encoding.
package cnt_pkg;

  localparam bit CNT_DOWN = 1'b0;
  localparam bit CNT_UP   = 1'b1;

  function automatic int cnt_width(input int mod);
    return $clog2(mod);
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/mod_updn_count_if.sv
// Control/status bundle of mod_updn_count.
// q_gray exists only with MOD_UPDN_COUNT_GRAY_EN defined.
interface mod_updn_count_if #(
  parameter int W = 4
);
  logic         en;
  logic         up;
  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         tc;
  logic         wrap;
  logic         load_err;
`ifdef MOD_UPDN_COUNT_GRAY_EN
  logic [W-1:0] q_gray;

  modport master (
    output en, up, clr, load, load_val,
    input  q, tc, wrap, load_err, q_gray
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output q, tc, wrap, load_err, q_gray
  );
`else
  modport master (
    output en, up, clr, load, load_val,
    input  q, tc, wrap, load_err
  );

  modport slave (
    input  en, up, clr, load, load_val,
    output q, tc, wrap, load_err
  );
`endif
endinterface

// File: rtl/tff.sv
// Single T flip-flop with async active-high reset.
// Reset value is chosen per instance.
module tff #(
  parameter bit RST_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_t,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RST_VALUE;
    end else if (i_t) begin
      r_q <= ~r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mod_updn_count.sv
// Modulo-MOD up/down counter built from per-bit T flip-flops.
// Optional q_gray output with MOD_UPDN_COUNT_GRAY_EN.
module mod_updn_count
  import cnt_pkg::*;
#(
  parameter int MOD       = 10,
  parameter int RST_VALUE = 0
) (
  input  logic            clk,
  input  logic            rst,
  mod_updn_count_if.slave bus
);

  localparam int W  = cnt_width(MOD);
  localparam int W1 = W + 1;

  localparam logic [W:0]   L_MAX = W1'(MOD - 1);
  localparam logic [W:0]   L_MOD = W1'(MOD);
  localparam logic [W-1:0] L_RST = W'(RST_VALUE);

  logic [W-1:0] w_q;
  logic [W-1:0] w_q_next;
  logic [W-1:0] w_t;
  logic [W:0]   w_q_ext;
  logic [W:0]   w_lv_ext;
  logic         w_at_max;
  logic         w_at_min;
  logic         w_wrap_n;
  logic         w_lerr_n;
  logic         r_wrap;
  logic         r_lerr;

  // Compares at W+1 bits so MOD-1 == 2^W-1 cannot alias.
  assign w_q_ext  = {1'b0, w_q};
  assign w_lv_ext = {1'b0, bus.load_val};
  assign w_at_max = (w_q_ext == L_MAX);
  assign w_at_min = (w_q_ext == '0);

  always_comb begin
    w_q_next = w_q;
    w_wrap_n = 1'b0;
    w_lerr_n = 1'b0;
    priority case (1'b1)
      bus.clr: begin
        w_q_next = '0;
      end
      bus.load: begin
        if (w_lv_ext >= L_MOD) begin
          w_q_next = L_MAX[W-1:0];
          w_lerr_n = 1'b1;
        end else begin
          w_q_next = bus.load_val;
        end
      end
      bus.en: begin
        if (bus.up == CNT_UP) begin
          if (w_at_max) begin
            w_q_next = '0;
            w_wrap_n = 1'b1;
          end else begin
            w_q_next = w_q + W'(1);
          end
        end else begin
          if (w_at_min) begin
            w_q_next = L_MAX[W-1:0];
            w_wrap_n = 1'b1;
          end else begin
            w_q_next = w_q - W'(1);
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign w_t = w_q ^ w_q_next;

  for (genvar i = 0; i < W; i++) begin : g_bit
    tff #(
      .RST_VALUE(L_RST[i])
    ) u_tff (
      .clk(clk),
      .rst(rst),
      .i_t(w_t[i]),
      .o_q(w_q[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrap <= 1'b0;
      r_lerr <= 1'b0;
    end else begin
      r_wrap <= w_wrap_n;
      r_lerr <= w_lerr_n;
    end
  end

`ifdef MOD_UPDN_COUNT_GRAY_EN
  localparam logic [W-1:0] L_GRAY = W'(bin2gray(32'(RST_VALUE)));

  logic [W-1:0] r_gray;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gray <= L_GRAY;
    end else begin
      r_gray <= W'(bin2gray(32'(w_q_next)));
    end
  end

  assign bus.q_gray = r_gray;
`endif

  assign bus.q        = w_q;
  assign bus.wrap     = r_wrap;
  assign bus.load_err = r_lerr;
  assign bus.tc       = bus.en &
                        ((bus.up == CNT_UP) ? w_at_max : w_at_min);

endmodule
